gf180mcu_nand3_bist_ctrl: RTL and testbench



---
 rtl/gf180mcu_nand3_bist_pkg.sv | 22 ++
 rtl/gf180mcu_nand3_bist_vecgen.sv | 56 +++++
 rtl/gf180mcu_nand3_bist_ctrl.sv | 169 ++++++++++++++++
 tb/tb_gf180mcu_nand3_bist_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_nand3_bist_pkg.sv
// Shared definitions for the gf180mcu NAND3 built-in self-test controller.
//   state_t : controller states (IDLE, SETTLE, CHECK, DONE)
//   VEC_W   : width of the stimulus vector {A3,A2,A1}
//   exp_zn  : reference NAND3 output for a given stimulus vector
package gf180mcu_nand3_bist_pkg;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Truth value of a healthy NAND3 cell: low only when all inputs are high.
  function automatic logic exp_zn(input logic [VEC_W-1:0] vec);
    return ~&vec;
  endfunction

endpackage

// File: rtl/gf180mcu_nand3_bist_vecgen.sv
// Stimulus vector and sweep counter for the NAND3 BIST controller.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart at vector 0, sweep 0
//   adv        : step to the next vector (wraps 7->0 and bumps the sweep count)
//   vec        : current vector {A3,A2,A1}
//   vec_nxt    : value vec takes at the next edge (lets the top register drives in step)
//   last       : current vector is the final vector of the final sweep
module gf180mcu_nand3_bist_vecgen
  import gf180mcu_nand3_bist_pkg::*;
#(
  parameter int PASSES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [VEC_W-1:0] vec,
  output logic [VEC_W-1:0] vec_nxt,
  output logic             last
);

  localparam int PASS_W = $clog2(PASSES + 1);

  logic [PASS_W-1:0] pass_cnt;
  logic [PASS_W-1:0] pass_nxt;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    vec_nxt  = vec;
    pass_nxt = pass_cnt;
    if (clr) begin
      vec_nxt  = '0;
      pass_nxt = '0;
    end else if (adv) begin
      vec_nxt = vec + VEC_W'(1);
      if (vec == VEC_LAST) pass_nxt = pass_cnt + PASS_W'(1);
    end
  end

  // NOTE: registers use non-blocking assignments so all flops sample their
  // inputs from the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec      <= '0;
      pass_cnt <= '0;
    end else begin
      vec      <= vec_nxt;
      pass_cnt <= pass_nxt;
    end
  end

  assign last = (vec == VEC_LAST) && (pass_cnt == PASS_W'(PASSES - 1));

endmodule

// File: rtl/gf180mcu_nand3_bist_ctrl.sv
// Built-in self-test sequencer for one gf180mcu mcu7t5v0 NAND3 cell.
// Walks all eight input vectors into the cell, holds each for SETTLE_CYCLES,
// samples ZN against the NAND3 truth table, and repeats for PASSES sweeps.
// Ports:
//   CLK, RN              : clock, synchronous active-low reset
//   START, ABORT         : run request (IDLE only) / run termination (highest priority)
//   SENSE_ZN             : ZN of the cell under test
//   DRV_A1..DRV_A3       : registered stimulus to the cell
//   BUSY, DONE           : run in progress / one-cycle normal-completion pulse
//   PASS                 : last completed run had zero mismatches
//   ERR_CNT              : saturating mismatch count
//   FAIL_VEC, FAIL_VALID : first failing vector {A3,A2,A1} and its valid flag
module gf180mcu_nand3_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 4,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic             SENSE_ZN,
  output logic             DRV_A1,
  output logic             DRV_A2,
  output logic             DRV_A3,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       FAIL_VEC,
  output logic             FAIL_VALID
);

  import gf180mcu_nand3_bist_pkg::*;

  // The DONE port shadows the imported DONE state, so the state is always
  // referenced with its package scope.
  localparam state_t ST_DONE  = gf180mcu_nand3_bist_pkg::DONE;
  localparam int     SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [VEC_W-1:0]   vec;
  logic [VEC_W-1:0]   vec_nxt;
  logic [VEC_W-1:0]   drv;
  logic               vg_clr;
  logic               vg_adv;
  logic               vg_last;
  logic               accept;
  logic               abort_run;
  logic               check_en;
  logic               finish;
  logic               mismatch;
  logic [ERR_W-1:0]   err_cnt;
  logic [ERR_W-1:0]   err_nxt;
  logic [VEC_W-1:0]   fail_vec;
  logic               fail_valid;
  logic               pass_q;

  gf180mcu_nand3_bist_vecgen #(
    .PASSES(PASSES)
  ) u_vecgen (
    .clk    (CLK),
    .rst_n  (RN),
    .clr    (vg_clr),
    .adv    (vg_adv),
    .vec    (vec),
    .vec_nxt(vec_nxt),
    .last   (vg_last)
  );

  always_ff @(posedge CLK) begin
    if (!RN) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vg_clr    = 1'b0;
    vg_adv    = 1'b0;
    accept    = 1'b0;
    abort_run = 1'b0;
    check_en  = 1'b0;
    finish    = 1'b0;
    if (state != IDLE && ABORT) begin
      abort_run = 1'b1;
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (START && !ABORT) begin
            accept    = 1'b1;
            vg_clr    = 1'b1;
            state_nxt = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) state_nxt = CHECK;
        end
        CHECK: begin
          check_en = 1'b1;
          if (vg_last) begin
            finish    = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            vg_adv    = 1'b1;
            state_nxt = SETTLE;
          end
        end
        ST_DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counts cycles spent in SETTLE; restarts whenever SETTLE is (re)entered.
  always_ff @(posedge CLK) begin
    if (!RN)                                         settle_cnt <= '0;
    else if (state == SETTLE && state_nxt == SETTLE) settle_cnt <= settle_cnt + SETTLE_W'(1);
    else                                             settle_cnt <= '0;
  end

  // Drives follow the vector counter on the same edge while a run is active
  // and park at 0 otherwise, so the cell sees a registered, glitch-free input.
  always_ff @(posedge CLK) begin
    if (!RN)                                          drv <= '0;
    else if (state_nxt == SETTLE || state_nxt == CHECK) drv <= vec_nxt;
    else                                              drv <= '0;
  end

  assign mismatch = check_en && (SENSE_ZN != exp_zn(vec));
  assign err_nxt  = (mismatch && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
      pass_q     <= 1'b0;
    end else if (accept) begin
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
      pass_q     <= 1'b0;
    end else if (abort_run) begin
      pass_q <= 1'b0;
    end else if (check_en) begin
      err_cnt <= err_nxt;
      if (mismatch && !fail_valid) begin
        fail_vec   <= vec;
        fail_valid <= 1'b1;
      end
      // PASS must already reflect the final sweep's last comparison.
      if (finish) pass_q <= (err_nxt == '0);
    end
  end

  assign DRV_A1     = drv[0];
  assign DRV_A2     = drv[1];
  assign DRV_A3     = drv[2];
  assign BUSY       = (state == SETTLE) || (state == CHECK);
  assign DONE       = (state == ST_DONE);
  assign PASS       = pass_q;
  assign ERR_CNT    = err_cnt;
  assign FAIL_VEC   = fail_vec;
  assign FAIL_VALID = fail_valid;

endmodule

// File: tb/tb_gf180mcu_nand3_bist_ctrl.sv
// Self-checking bench for gf180mcu_nand3_bist_ctrl: a timeline model of a run
// is compared with the default-parameter DUT every cycle, and directed runs
// pin the model with hand-computed results. A second DUT with PASSES=64
// exercises error-counter saturation.
module tb_gf180mcu_nand3_bist_ctrl;

  localparam int S = 2;
  localparam int P = 4;
  localparam int N = 8 * P * (S + 1);

  logic       clk = 1'b0;
  logic       rn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       start64 = 1'b0;
  logic [1:0] mode = 2'd0;  // 0: healthy NAND3, 1: ZN tied 1, 2: ZN tied 0
  logic       sense;

  logic       a1, a2, a3, busy, done, pass, fvalid;
  logic [7:0] err;
  logic [2:0] fvec;

  logic       d64_a1, d64_a2, d64_a3, d64_busy, d64_done, d64_pass, d64_fvalid;
  logic [7:0] d64_err;
  logic [2:0] d64_fvec;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  assign sense = (mode == 2'd0) ? ~(a1 & a2 & a3) : (mode == 2'd1);

  gf180mcu_nand3_bist_ctrl dut (
    .CLK(clk), .RN(rn), .START(start), .ABORT(abort), .SENSE_ZN(sense),
    .DRV_A1(a1), .DRV_A2(a2), .DRV_A3(a3), .BUSY(busy), .DONE(done),
    .PASS(pass), .ERR_CNT(err), .FAIL_VEC(fvec), .FAIL_VALID(fvalid)
  );

  gf180mcu_nand3_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(64), .ERR_W(8)) dut64 (
    .CLK(clk), .RN(rn), .START(start64), .ABORT(abort), .SENSE_ZN(1'b0),
    .DRV_A1(d64_a1), .DRV_A2(d64_a2), .DRV_A3(d64_a3), .BUSY(d64_busy),
    .DONE(d64_done), .PASS(d64_pass), .ERR_CNT(d64_err), .FAIL_VEC(d64_fvec),
    .FAIL_VALID(d64_fvalid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Run model: m_t counts cycles since the accepting edge. Vector index k
  // occupies cycles k*(S+1) .. k*(S+1)+S and is judged at the edge closing
  // its last cycle; after 8*P vectors comes one DONE cycle.
  int         m_phase = 0;  // 0 idle, 1 running, 2 done cycle
  int         m_t = 0;
  logic [7:0] m_err = '0;
  logic [2:0] m_fvec = '0;
  logic       m_fvalid = 1'b0;
  logic       m_pass = 1'b0;
  logic [2:0] m_v;

  always @(posedge clk) begin
    if (!rn) begin
      m_phase = 0; m_err = '0; m_fvec = '0; m_fvalid = 1'b0; m_pass = 1'b0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin
             m_phase = 1; m_t = 0;
             m_err = '0; m_fvec = '0; m_fvalid = 1'b0; m_pass = 1'b0;
           end
        1: if (abort) begin
             m_phase = 0; m_pass = 1'b0;
           end else begin
             if ((m_t + 1) % (S + 1) == 0) begin
               m_v = 3'((m_t / (S + 1)) % 8);
               if (sense !== ~&m_v) begin
                 if (m_err != 8'hff) m_err = m_err + 8'd1;
                 if (!m_fvalid) begin m_fvec = m_v; m_fvalid = 1'b1; end
               end
             end
             m_t++;
             if (m_t == N) begin m_phase = 2; m_pass = (m_err == 0); end
           end
        default: begin
          m_phase = 0;
          if (abort) m_pass = 1'b0;
        end
      endcase
    end
  end

  function automatic logic [17:0] model_out();
    logic [2:0] d;
    d = (m_phase == 1) ? 3'((m_t / (S + 1)) % 8) : 3'd0;
    return {m_phase == 1, m_phase == 2, m_pass, m_fvalid, m_fvec, m_err, d};
  endfunction

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle {busy,done,pass,fvalid,fvec,err,a3a2a1}",
            32'({busy, done, pass, fvalid, fvec, err, a3, a2, a1}), 32'(model_out()));
  end

  // Returns at the negedge after the accepting edge ("edge 0").
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int e);
    e = 0;
    while (!done && e < limit) begin
      @(negedge clk); e++;
    end
  endtask

  task automatic results(input string tag, input logic p, input logic [7:0] ec,
                         input logic [2:0] fv, input logic fval);
    check({tag, " PASS"}, 32'(pass), 32'(p));
    check({tag, " ERR_CNT"}, 32'(err), 32'(ec));
    check({tag, " FAIL_VEC"}, 32'(fvec), 32'(fv));
    check({tag, " FAIL_VALID"}, 32'(fvalid), 32'(fval));
  endtask

  initial begin
    int e;
    int dones;

    repeat (3) @(negedge clk);
    check("reset outputs", 32'({busy, done, pass, fvalid, fvec, err, a3, a2, a1}), 32'd0);
    rn = 1'b1;
    cmp_en = 1'b1;

    // Healthy cell: clean run, DONE at edge 96.
    mode = 2'd0;
    pulse_start();
    wait_done(200, e);
    check("nand DONE edge", 32'(e), 32'd96);
    results("nand", 1'b1, 8'd0, 3'd0, 1'b0);
    @(negedge clk);
    check("nand results hold", 32'({pass, err, fvalid}), 32'({1'b1, 8'd0, 1'b0}));

    // ZN stuck at 1: only vector 7 fails, once per sweep.
    mode = 2'd1;
    pulse_start();
    wait_done(200, e);
    check("tie1 DONE edge", 32'(e), 32'd96);
    results("tie1", 1'b0, 8'd4, 3'd7, 1'b1);

    // ZN stuck at 0: vectors 0..6 fail each sweep; a START mid-run is ignored.
    mode = 2'd2;
    pulse_start();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = 21;
    while (!done && e < 200) begin @(negedge clk); e++; end
    check("tie0 DONE edge", 32'(e), 32'd96);
    results("tie0", 1'b0, 8'd28, 3'd0, 1'b1);

    // ABORT sampled at edge 41 of a ZN-stuck-1 run (one mismatch so far).
    mode = 2'd1;
    @(negedge clk);
    pulse_start();
    repeat (40) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort BUSY", 32'(busy), 32'd0);
    check("abort drives", 32'({a3, a2, a1}), 32'd0);
    results("abort", 1'b0, 8'd1, 3'd7, 1'b1);
    dones = 0;
    repeat (100) begin @(negedge clk); if (done) dones++; end
    check("abort no DONE", 32'(dones), 32'd0);
    check("abort ERR_CNT held", 32'(err), 32'd1);

    // Reset sampled at edge 50 of a run, then a clean run.
    pulse_start();
    repeat (49) @(negedge clk);
    rn = 1'b0;
    @(negedge clk);
    check("midrun reset outputs", 32'({busy, done, pass, fvalid, fvec, err, a3, a2, a1}), 32'd0);
    rn = 1'b1;
    mode = 2'd0;
    pulse_start();
    wait_done(200, e);
    check("post-reset DONE edge", 32'(e), 32'd96);
    results("post-reset", 1'b1, 8'd0, 3'd0, 1'b0);

    // PASSES=64, ZN stuck at 0: 448 mismatches saturate at 255.
    @(negedge clk); start64 = 1'b1;
    @(posedge clk);
    @(negedge clk); start64 = 1'b0;
    e = 0;
    while (!d64_done && e < 2000) begin @(negedge clk); e++; end
    check("sat DONE edge", 32'(e), 32'd1536);
    check("sat ERR_CNT", 32'(d64_err), 32'd255);
    check("sat FAIL_VEC", 32'(d64_fvec), 32'd0);
    check("sat FAIL_VALID/PASS", 32'({d64_fvalid, d64_pass}), 32'b10);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
